// File: rtl/pll_cen_pkg.sv
// Shared constants and helpers for the multi-channel fractional clock-enable generator.
// The parameter bounds and the lock counter sizing live here so every file agrees on them.
package pll_cen_pkg;

  localparam int ACC_W_MIN = 16;
  localparam int ACC_W_MAX = 48;
  localparam int ACC_W_DEF = 32;
  localparam int NUM_CH_MAX = 8;

  typedef logic [ACC_W_DEF-1:0] inc_t;

  // Width that can hold 0..lock_cycles-1; never narrower than one bit.
  function automatic int lock_cnt_w(input int lock_cycles);
    return (lock_cycles > 2) ? $clog2(lock_cycles) : 1;
  endfunction

  // Channel-select width; a single-channel build still needs a 1-bit port.
  function automatic int ch_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pll_cen_chan.sv
// One phase-accumulator channel: accumulates its increment every refclk, emits a carry pulse
// and the accumulator MSB, and swaps in a pending increment only on a period boundary.
module pll_cen_chan
  import pll_cen_pkg::*;
#(
  parameter int               ACC_W   = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEF_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_val,
  input  logic             sync,
  output logic             pend,
  output logic             cen,
  output logic             outclk,
  output logic             apply
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] pend_val;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             stopped;

  assign sum     = {1'b0, acc} + {1'b0, inc};
  assign carry   = sum[ACC_W];
  assign stopped = (inc == '0);

  // A running channel retunes only on its wrap so the new rate starts on a period boundary;
  // phase_sync suppresses that wrap, but a stopped channel has no boundary to wait for.
  assign apply = pend && (stopped || (carry && !sync));

  // NOTE: every register here is written with <= so all channels and the lock counter see
  // the same pre-edge values; blocking assignments would make results depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      inc      <= DEF_INC;
      pend_val <= '0;
      pend     <= 1'b0;
      cen      <= 1'b0;
      outclk   <= 1'b0;
    end else begin
      if (sync) begin
        acc    <= '0;
        cen    <= 1'b0;
        outclk <= 1'b0;
      end else begin
        acc    <= sum[ACC_W-1:0];
        cen    <= carry;
        outclk <= sum[ACC_W-1];
      end

      if (apply) inc <= pend_val;

      // A write in the same cycle as an apply re-arms pend with the newer value.
      if (wr) begin
        pend_val <= wr_val;
        pend     <= 1'b1;
      end else if (apply) begin
        pend     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pll_cen_nco.sv
// Multi-channel fractional clock-enable generator (f = f_ref * inc / 2^ACC_W per channel):
// write decode, phase_sync fan-out and a lock indicator that tracks configuration stability.
module pll_cen_nco
  import pll_cen_pkg::*;
#(
  parameter int                      NUM_CH      = 2,
  parameter int                      ACC_W       = 32,
  parameter int                      LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_INC     = '0,
  localparam int                     CH_W        = ch_sel_w(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              inc_wr,
  input  logic [CH_W-1:0]   inc_ch,
  input  logic [ACC_W-1:0]  inc_val,
  input  logic              phase_sync,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] outclk_cen,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam int              CNT_W   = lock_cnt_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES - 1);

  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] apply_vec;
  logic              lock_clear;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  // An out-of-range channel index matches no slot, so the write simply disappears.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_sel[i] = inc_wr && (inc_ch == CH_W'(i));

    pll_cen_chan #(
      .ACC_W   (ACC_W),
      .DEF_INC (DEF_INC[i*ACC_W +: ACC_W])
    ) u_chan (
      .clk    (refclk),
      .rst    (rst),
      .wr     (wr_sel[i]),
      .wr_val (inc_val),
      .sync   (phase_sync),
      .pend   (pend[i]),
      .cen    (outclk_cen[i]),
      .outclk (outclk[i]),
      .apply  (apply_vec[i])
    );
  end

  assign lock_clear = (|apply_vec) || phase_sync;

  // NOTE: cnt_nxt takes its default before any branch, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    cnt_nxt = lock_cnt;
    if (lock_clear) begin
      cnt_nxt = '0;
    end else if (lock_cnt != CNT_MAX) begin
      cnt_nxt = lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      lock_cnt <= cnt_nxt;
      locked   <= (cnt_nxt == CNT_MAX);
    end
  end

endmodule

// File: tb/tb_pll_cen_nco.sv
// Self-checking bench for pll_cen_nco: directed retune/sync/lock scenarios plus random traffic,
// all compared each cycle against an arithmetic model of the accumulators.
module tb_pll_cen_nco;
  import pll_cen_pkg::*;

  localparam int NUM_CH      = 2;
  localparam int ACC_W       = 32;
  localparam int LOCK_CYCLES = 16;
  localparam logic [NUM_CH*ACC_W-1:0] DEF = {32'h1000_0000, 32'h4000_0000};
  localparam longint TWO32 = 64'h1_0000_0000;
  localparam longint TWO31 = 64'h0_8000_0000;

  logic              refclk = 1'b0;
  logic              rst = 1'b1;
  logic              inc_wr = 1'b0;
  logic [0:0]        inc_ch = '0;
  logic [ACC_W-1:0]  inc_val = '0;
  logic              phase_sync = 1'b0;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] outclk_cen;
  logic [NUM_CH-1:0] outclk;
  logic              locked;

  pll_cen_nco #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .DEF_INC     (DEF)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .inc_wr     (inc_wr),
    .inc_ch     (inc_ch),
    .inc_val    (inc_val),
    .phase_sync (phase_sync),
    .pend       (pend),
    .outclk_cen (outclk_cen),
    .outclk     (outclk),
    .locked     (locked)
  );

  always #5 refclk = ~refclk;

  // Reference model: plain integer phase arithmetic per channel.
  longint m_acc  [NUM_CH];
  longint m_inc  [NUM_CH];
  longint m_pval [NUM_CH];
  bit     m_pend [NUM_CH];
  bit     m_cen  [NUM_CH];
  bit     m_clk  [NUM_CH];
  int     m_stable;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_acc[c]  = 0;
      m_inc[c]  = longint'(DEF[c*ACC_W +: ACC_W]);
      m_pval[c] = 0;
      m_pend[c] = 0;
      m_cen[c]  = 0;
      m_clk[c]  = 0;
    end
    m_stable = 0;
  endtask

  // One refclk edge worth of behaviour, using the inputs present at that edge.
  task automatic model_step();
    bit any_take = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      longint total = m_acc[c] + m_inc[c];
      bit     wrap  = (total >= TWO32);
      bit     take  = m_pend[c] && (m_inc[c] == 0 || (wrap && !phase_sync));
      m_acc[c] = phase_sync ? 0 : total % TWO32;
      m_cen[c] = !phase_sync && wrap;
      m_clk[c] = !phase_sync && (m_acc[c] >= TWO31);
      if (take) m_inc[c] = m_pval[c];
      if (inc_wr && int'(inc_ch) == c) begin
        m_pval[c] = longint'(inc_val);
        m_pend[c] = 1;
      end else if (take) begin
        m_pend[c] = 0;
      end
      any_take |= take;
    end
    if (any_take || phase_sync) m_stable = 0;
    else if (m_stable < LOCK_CYCLES) m_stable++;
  endtask

  task automatic check_outputs(input string tag);
    logic [NUM_CH-1:0] e_pend, e_cen, e_clk;
    for (int c = 0; c < NUM_CH; c++) begin
      e_pend[c] = m_pend[c];
      e_cen[c]  = m_cen[c];
      e_clk[c]  = m_clk[c];
    end
    check({tag, ".pend"},   64'(pend),       64'(e_pend));
    check({tag, ".cen"},    64'(outclk_cen), 64'(e_cen));
    check({tag, ".outclk"}, 64'(outclk),     64'(e_clk));
    check({tag, ".locked"}, 64'(locked),     64'(m_stable >= LOCK_CYCLES - 1));
  endtask

  // Inputs are set at a negedge; the model steps on the posedge, outputs are compared at the next negedge.
  task automatic tick();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    check_outputs("cyc");
    inc_wr     = 1'b0;
    phase_sync = 1'b0;
  endtask

  task automatic write(input int ch, input logic [ACC_W-1:0] val);
    inc_wr  = 1'b1;
    inc_ch  = 1'(ch);
    inc_val = val;
    tick();
  endtask

  task automatic sync_pulse();
    phase_sync = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_outputs("rst");
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic count_cen(input int ch, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (outclk_cen[ch]) cnt++;
    end
  endtask

  task automatic wait_applied(input int ch, input int budget, input string tag);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      if (!pend[ch]) done = 1;
    end
    check({tag, ".applied"}, 64'(done), 64'd1);
  endtask

  function automatic logic [ACC_W-1:0] rand_inc();
    inc_t v;
    case ($urandom_range(0, 4))
      0:       v = '0;
      1:       v = $urandom;
      2:       v = $urandom >> 8;
      3:       v = 32'h8000_0000 | $urandom;
      default: v = $urandom >> 3;
    endcase
    return v;
  endfunction

  initial begin
    int  cnt;
    bit  done;

    @(negedge refclk);
    do_reset();

    // Default rates and lock after reset release.
    cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (outclk_cen[0]) cnt++;
      if (k == 14) check("lock_early", 64'(locked), 64'd0);
      if (k == 15) check("lock_on_time", 64'(locked), 64'd1);
      if (k == 16) check("ch1_first_wrap", 64'(outclk_cen[1]), 64'd1);
    end
    check("ch0_rate4", 64'(cnt), 64'd4);

    sync_pulse();
    check("sync_unlock", 64'(locked), 64'd0);

    // Mid-period retune of ch0 waits for the wrap, then runs at period 2.
    tick();
    write(0, 32'h8000_0000);
    check("retune_pending", 64'(pend[0]), 64'd1);
    wait_applied(0, 8, "retune");
    check("retune_on_wrap", 64'(outclk_cen[0]), 64'd1);
    count_cen(0, 8, cnt);
    check("ch0_rate2", 64'(cnt), 64'd4);

    // Stop ch1, then start it: applied the next cycle, first pulse 8 cycles on.
    write(1, 32'h0);
    wait_applied(1, 20, "stop");
    write(1, 32'h2000_0000);
    check("start_pending", 64'(pend[1]), 64'd1);
    tick();
    check("start_applied", 64'(pend[1]), 64'd0);
    check("start_unlock", 64'(locked), 64'd0);
    cnt = 0;
    done = 0;
    for (int k = 1; k <= 12 && !done; k++) begin
      tick();
      if (outclk_cen[1]) begin
        cnt = k;
        done = 1;
      end
    end
    check("start_first_cen", 64'(cnt), 64'd8);

    // Two writes before the wrap: only the last value takes effect.
    write(0, 32'h0800_0000);
    wait_applied(0, 8, "slow");
    write(0, 32'h1000_0000);
    write(0, 32'h2000_0000);
    wait_applied(0, 40, "double");
    cnt = 0;
    done = 0;
    for (int k = 1; k <= 12 && !done; k++) begin
      tick();
      if (outclk_cen[0]) begin
        cnt = k;
        done = 1;
      end
    end
    check("double_last_wins", 64'(cnt), 64'd8);

    // phase_sync landing on a carrying cycle swallows the pulse.
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (m_acc[0] + m_inc[0] >= TWO32) begin
        sync_pulse();
        check("sync_carry_cen", 64'(outclk_cen), 64'd0);
        check("sync_carry_clk", 64'(outclk), 64'd0);
        done = 1;
      end else begin
        tick();
      end
    end
    check("sync_carry_found", 64'(done), 64'd1);

    // Reset while a write is pending discards it.
    write(0, 32'h1234_5678);
    do_reset();
    check("rst_pend_lost", 64'(pend), 64'd0);
    count_cen(0, 8, cnt);
    check("rst_default_rate", 64'(cnt), 64'd2);

    // Random traffic against the model, with an occasional reset.
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        inc_wr  = 1'b1;
        inc_ch  = 1'($urandom_range(0, NUM_CH - 1));
        inc_val = rand_inc();
      end
      if ($urandom_range(0, 49) == 0) phase_sync = 1'b1;
      if (n == 350) begin
        inc_wr     = 1'b0;
        phase_sync = 1'b0;
        do_reset();
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
